// File: rtl/alu_issue.sv
// Single-entry issue stage between fetch and the ALU. It decodes an RV32IM
// OP/OP-IMM/LUI instruction, reads operands with write-back bypass, and holds one request.
module alu_issue #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic [6:0]       opcode;
  logic [2:0]       f3_field;
  logic [6:0]       f7_field;
  logic [1:0][4:0]  src_addr;
  logic [1:0][31:0] src_data;
  logic [1:0][31:0] operand;
  logic             accept;
  logic             legal;

  logic [31:0] a_next, b_next;
  logic [2:0]  funct3_next;
  logic [6:0]  funct7_next;
  logic [4:0]  rd_next;
  logic        illegal_next;

  logic        valid_reg;
  logic [31:0] a_reg, b_reg;
  logic [2:0]  funct3_reg;
  logic [6:0]  funct7_reg;
  logic [4:0]  rd_reg;
  logic        illegal_reg;

  assign opcode      = in_instr[6:0];
  assign f3_field    = in_instr[14:12];
  assign f7_field    = in_instr[31:25];
  assign src_addr[0] = in_instr[19:15];
  assign src_addr[1] = in_instr[24:20];
  assign src_data[0] = rs1_data;
  assign src_data[1] = rs2_data;
  assign rs1_addr    = src_addr[0];
  assign rs2_addr    = src_addr[1];

  assign in_ready = !rst && !flush && (!valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // x0 wins over forwarding; bypass only matters in the accept cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign operand[gi] = (src_addr[gi] == 5'd0) ? 32'd0 :
                         (FWD_EN && wb_en && (wb_rd == src_addr[gi])) ? wb_data :
                         src_data[gi];
  end

  always_comb begin
    a_next      = operand[0];
    b_next      = operand[1];
    funct3_next = f3_field;
    funct7_next = 7'd0;
    rd_next     = in_instr[11:7];
    legal       = 1'b0;
    case (opcode)
      OPC_OP: begin
        funct7_next = f7_field;
        legal = (f7_field == 7'b0000000) || (f7_field == 7'b0000001) ||
                ((f7_field == 7'b0100000) && ((f3_field == 3'b000) || (f3_field == 3'b101)));
      end
      OPC_OP_IMM: begin
        b_next = {{20{in_instr[31]}}, in_instr[31:20]};
        legal  = 1'b1;
        if (f3_field == 3'b001) begin
          legal = (f7_field == 7'd0);
        end else if (f3_field == 3'b101) begin
          // Only shift-right immediates carry a funct7 (SRLI vs SRAI).
          funct7_next = f7_field;
          legal = (f7_field == 7'b0000000) || (f7_field == 7'b0100000);
        end
      end
      OPC_LUI: begin
        a_next      = 32'd0;
        b_next      = {in_instr[31:12], 12'd0};
        funct3_next = 3'd0;
        legal       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    illegal_next = !legal;
    if (!legal) begin
      a_next      = 32'd0;
      b_next      = 32'd0;
      funct3_next = 3'd0;
      funct7_next = 7'd0;
      rd_next     = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      funct3_reg  <= '0;
      funct7_reg  <= '0;
      rd_reg      <= '0;
      illegal_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg   <= 1'b1;
      a_reg       <= a_next;
      b_reg       <= b_next;
      funct3_reg  <= funct3_next;
      funct7_reg  <= funct7_next;
      rd_reg      <= rd_next;
      illegal_reg <= illegal_next;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid   = valid_reg;
  assign out_a       = a_reg;
  assign out_b       = b_reg;
  assign out_funct3  = funct3_reg;
  assign out_funct7  = funct7_reg;
  assign out_rd      = rd_reg;
  assign out_illegal = illegal_reg;
endmodule

// File: doc/alu_issue.md
# alu_issue

Single-entry issue stage that sits between instruction fetch and the `alu` execute block. It accepts a 32-bit RV32IM instruction over a valid/ready handshake, decodes it, and reads operands from the register file with optional write-back forwarding. It registers the ALU request (`a`, `b`, `funct3`, `funct7`, `rd`) and presents it to execute over a second valid/ready handshake.

## Interface
- `FWD_EN`, default 1: when 1, bypass `wb_data` onto a matching source operand; when 0, use the register-file data only.
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  fetch presents `in_instr`
- `in_ready`  out  1  stage can accept this cycle (combinational)
- `in_instr`  in  32  instruction word
- `rs1_addr`  out  5  `in_instr[19:15]`, combinational register-file read address
- `rs2_addr`  out  5  `in_instr[24:20]`, combinational register-file read address
- `rs1_data`  in  32  register-file read data for `rs1_addr`, same cycle
- `rs2_data`  in  32  register-file read data for `rs2_addr`, same cycle
- `wb_en`  in  1  write-back occurring this cycle
- `wb_rd`  in  5  write-back destination register
- `wb_data`  in  32  write-back value
- `flush`  in  1  discard the held request
- `out_valid`  out  1  registered request present
- `out_ready`  in  1  execute consumes the request
- `out_a`  out  32  ALU operand a
- `out_b`  out  32  ALU operand b
- `out_funct3`  out  3  ALU funct3
- `out_funct7`  out  7  ALU funct7
- `out_rd`  out  5  destination register
- `out_illegal`  out  1  instruction not decodable by this stage

## Operation
- Handshake: `in_ready = !rst && !flush && (!out_valid || out_ready)`. An instruction is accepted when `in_valid && in_ready`.
- Register update priority: `rst` > `flush` > accept > consume.
  - `rst`: all outputs are cleared to 0.
  - `flush`: `out_valid` is cleared to 0; payload registers are don't-care.
  - accept: all payload registers load and `out_valid` is set to 1.
  - consume without accept (`out_ready`): `out_valid` is cleared to 0.
  - otherwise: all registers hold.
- Operand read: x0 always reads 0, irrespective of `rs*_data` and forwarding.
  - When `FWD_EN`, `wb_en`, `wb_rd == rsN` and `rsN != 0`, operand N takes `wb_data`.
  - Otherwise operand N takes `rsN_data`.
- Decode by opcode `in_instr[6:0]`:
  - `0110011` (OP): `a = rs1`, `b = rs2`, `funct3 = [14:12]`, `funct7 = [31:25]`.
    - Legal when `funct7` is `0000000`.
    - Legal when `funct7` is `0000001`.
    - Legal when `funct7` is `0100000` and `funct3` is `000` or `101`.
  - `0010011` (OP-IMM): `a = rs1`, `b = sign_extend([31:20])`, `funct3 = [14:12]`. `funct7` is forced to `0000000` except:
    - `funct3 = 001`: legal only when `[31:25] = 0`.
    - `funct3 = 101`: `funct7 = [31:25]`, legal only when that field is `0000000` or `0100000`.
    - `funct7` must never be `0000001` from OP-IMM.
  - `0110111` (LUI): `a = 0`, `b = {[31:12], 12'b0}`, `funct3 = 000`, `funct7 = 0000000`.
  - `rd = [11:7]` for all legal instructions.
- Illegal instructions (any other opcode, or a failing legality check) are still accepted and issued.
  - Payload: `out_illegal = 1`; `a`, `b`, `funct3`, `funct7` and `rd` are all 0.
  - Execute raises the trap; this stage does not stall on illegal instructions.
- `rd = 0` is issued unchanged; execute discards the result.

## Timing
- Reset values:
  - `out_valid` = 0, `out_illegal` = 0.
  - `out_a`, `out_b`, `out_funct3`, `out_funct7`, `out_rd` = 0.
  - `in_ready` = 0 while `rst` is high.
- Latency: an instruction accepted at edge N drives `out_valid = 1` with its payload after edge N.
- Throughput: one instruction per cycle while `out_ready` is held high.
- Stability: while `out_valid && !out_ready`, every `out_*` signal holds stable and `in_ready` is 0.
- Simultaneous consume and accept: the new payload replaces the old one and `out_valid` stays 1, with no bubble.
- Forwarding compares `wb_*` only in the accept cycle; later write-backs do not update a held request.
- `flush` in the same cycle as `in_valid` drops the incoming instruction, because `in_ready` is 0.
- Mid-operation `rst` drops the held request; the first accept is possible in the cycle after `rst` falls.

## Test plan
- Reset then `ADD x3,x1,x2` (`0x002081B3`) with `rs1_data = 5`, `rs2_data = 7` -> next cycle: `out_valid = 1`, `a = 5`, `b = 7`, `funct3 = 000`, `funct7 = 0000000`, `rd = 3`, `out_illegal = 0`.
- `ADDI x1,x0,-1` (`0xFFF00093`) -> `a = 0`, `b = 0xFFFFFFFF`, `funct7 = 0000000` (immediate bits must not leak); `SRAI x1,x1,3` (`0x4030D093`) -> `funct7 = 0100000`, `b[4:0] = 3`.
- `MUL x5,x6,x7` (`0x027302B3`) with `wb_en = 1`, `wb_rd = 6`, `wb_data = 0x1234`, `rs1_data = 0` -> `a = 0x1234`, `funct7 = 0000001`; same stimulus with `wb_rd = 0` and rs1 = x0 -> `a = 0`.
- Backpressure: issue two back-to-back instructions with `out_ready = 0` for 3 cycles -> first payload stable and `in_ready = 0` throughout; raise `out_ready` -> second instruction issued the next cycle with no bubble.
- `flush` while `out_valid = 1` and `in_valid = 1` -> `out_valid = 0` next cycle and the input instruction is not accepted; `rst` asserted mid-stall -> all outputs 0 next cycle.
- Opcode `0x0000007F`, and OP with `funct7 = 0100000`, `funct3 = 001` -> `out_illegal = 1`, all payload fields 0, handshake completes normally.
